axis_burst_memory: RTL and testbench
====================================

Name: axis_burst_memory

Overview:
- Parametrised AXI-Stream memory; successor of the single-beat stream memory.
- Write side: packet-based AXIS slave with a start address, auto-incrementing address and per-byte strobes.
- Read side: command-driven burst reader on an AXIS master, with full valid/ready back-pressure and tlast on the final beat.
- Sits between DMA-style producers/consumers as a shared scratch buffer; single clock domain.

Parameters:
- MEM_SIZE, 4096, number of words; must be ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 12, word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- LEN_WIDTH, 8, burst length field width (beats minus 1).

Ports:
- axis_aclk  in  1  clock, all logic on rising edge
- axis_areset  in  1  synchronous, active-high reset
- s_axis_wr_addr  in  ADDR_WIDTH  packet start address, sampled on first beat only
- s_axis_tdata  in  DATA_WIDTH  write data
- s_axis_tstrb  in  DATA_WIDTH/8  byte write enables
- s_axis_tvalid  in  1  write beat valid
- s_axis_tlast  in  1  last beat of write packet
- s_axis_tready  out  1  write beat accept
- wr_pkt_done  out  1  one-cycle pulse after a packet's last beat is accepted
- rd_cmd_valid  in  1  read command valid
- rd_cmd_addr  in  ADDR_WIDTH  burst start address
- rd_cmd_len  in  LEN_WIDTH  burst beats minus 1
- rd_cmd_ready  out  1  read command accept
- m_axis_tdata  out  DATA_WIDTH  read data
- m_axis_tstrb  out  DATA_WIDTH/8  all ones whenever tvalid is high
- m_axis_tvalid  out  1  read beat valid
- m_axis_tlast  out  1  final beat of burst
- m_axis_tready  in  1  downstream accept

Behaviour:
- Reset (axis_areset=1 at a clock edge):
  - Outputs forced: s_axis_tready=0, rd_cmd_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0, wr_pkt_done=0.
  - Write state returns to first-beat, the read FSM returns to IDLE, skid buffer and in-flight reads are flushed.
  - Memory contents are preserved.
- Out of reset, s_axis_tready=1 constantly; the write path never stalls.
- Write beat = s_axis_tvalid & s_axis_tready:
  - First beat of a packet writes at s_axis_wr_addr; each later beat writes at previous address +1.
  - Address wraps MEM_SIZE-1 -> 0.
  - Byte lane i is written only if s_axis_tstrb[i]=1; other lanes keep old data.
  - A beat with tlast=1 closes the packet; the next beat is a first beat.
  - wr_pkt_done is high in the cycle after the tlast beat.
- Read FSM states:
  - IDLE: rd_cmd_ready=1. On rd_cmd_valid&rd_cmd_ready, capture addr and remaining=len, go to BURST.
  - BURST: rd_cmd_ready=0. Issue one memory read per cycle while credit is available. After issuing the beat with remaining==0, return to IDLE.
  - A new command may then be accepted while the previous burst drains.
- Read pipeline and back-pressure:
  - Memory read latency is 1 cycle into a 2-entry skid buffer (axis_skid_buffer).
  - Credit: buffered + in-flight < 2, evaluated so that tready=1 sustains 1 beat/cycle.
  - No beat is dropped or duplicated under any tready pattern.
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tstrb are held stable.
- Latency: command handshake at cycle C -> first read issued at C+1 -> m_axis_tvalid=1 at C+2.
- Read address wraps MEM_SIZE-1 -> 0.
- m_axis_tlast=1 only on beat len of each burst. len=0 gives a single beat with tlast=1.
- Same-cycle read and write to one address: read returns the old (pre-write) data.
- Reset mid-burst: the burst is aborted and m_axis_tvalid=0 from the cycle after the reset edge; no residual beats are emitted after release.

Decomposition:
- Package axis_mem_pkg holds:
  - the read FSM state enum (RD_IDLE, RD_BURST);
  - default parameter constants;
  - the derived STRB_WIDTH=DATA_WIDTH/8.
- One sub-module: axis_skid_buffer, a 2-entry valid/ready buffer carrying {tdata, tlast}, with sync active-high reset.
- Memory array, write logic and read FSM live in the top level.

Test Plan:
- Write 4 beats 0x11111111..0x44444444 at 0x010, strb 0xF; read addr 0x010 len 3 with tready=1 -> same 4 words in order, tlast only on the 4th, tvalid at C+2, 4 consecutive cycles, wr_pkt_done one pulse.
- Write 0xAABBCCDD at 0x020 strb 0xF, then 0x11223344 at 0x020 strb 0x5; read len 0 -> 0xAA22CC44, tlast=1.
- Write 3 beats A,B,C at 0xFFE; read len 2 at 0xFFE -> A,B,C, confirming location 0x000=C and wrap on both paths.
- Burst of 8 words (len 7) with tready pattern 1,0,0,1,0,1,1,0... -> exactly 8 beats in order, data stable during stalls, tlast on the 8th; a second command is accepted before the first drains and its beats follow with no gap when tready=1.
- Reset pulse at the 3rd beat of an 8-beat burst -> tvalid=0 next cycle, rd_cmd_ready=0 during reset and 1 after; a fresh read returns previously written data intact.
- Write 0x5 to 0x100 while a burst reads 0x100 in the same cycle (old value 0x9) -> read beat 0x9; a subsequent read returns 0x5.

Source files
------------

// File: rtl/axis_mem_pkg.sv
// Shared types and default sizing for the AXI-Stream burst memory.
package axis_mem_pkg;

    localparam int unsigned DEF_MEM_SIZE   = 4096;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LEN_WIDTH  = 8;
    localparam int unsigned STRB_WIDTH     = DEF_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        RD_IDLE,
        RD_BURST
    } rd_state_e;

endpackage

// File: rtl/axis_burst_memory_if.sv
// Write stream, read command and read stream signals of the burst memory.
interface axis_burst_memory_if import axis_mem_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] s_axis_wr_addr;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [StrbW-1:0]      s_axis_tstrb;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic                  wr_pkt_done;

    logic                  rd_cmd_valid;
    logic [ADDR_WIDTH-1:0] rd_cmd_addr;
    logic [LEN_WIDTH-1:0]  rd_cmd_len;
    logic                  rd_cmd_ready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [StrbW-1:0]      m_axis_tstrb;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_wr_addr, s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready, wr_pkt_done,
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output rd_cmd_ready,
        output m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_wr_addr, s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready, wr_pkt_done,
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  rd_cmd_ready,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready buffer; an empty buffer passes its input straight through.
module axis_skid_buffer #(
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [Width-1:0] entry_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q;
    logic             empty, push, pop_store;

    assign empty       = (count_q == 2'd0);
    assign out_valid_o = !empty || in_valid_i;
    assign out_data_o  = empty ? in_data_i : entry_q[rd_ptr_q];
    // Incoming data is stored unless it leaves in the same cycle via the bypass.
    assign push        = in_valid_i && !(empty && out_ready_i);
    assign pop_store   = !empty && out_ready_i;
    assign count_o     = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_store) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop_store};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            entry_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/axis_burst_memory.sv
// Shared scratch memory: packet writes on an AXIS slave, command-driven burst reads on an AXIS master.
module axis_burst_memory import axis_mem_pkg::*; #(
    parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                axis_aclk,
    input  logic                axis_areset,
    axis_burst_memory_if.slave  bus
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_SIZE - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Write path
    logic                  wr_first_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_pkt_done_q;
    logic                  wr_beat;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign bus.s_axis_tready = ~axis_areset;
    assign bus.wr_pkt_done   = wr_pkt_done_q & ~axis_areset;
    assign wr_beat           = bus.s_axis_tvalid & bus.s_axis_tready;
    assign wr_addr           = wr_first_q ? bus.s_axis_wr_addr : wr_addr_q;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wr_first_q    <= 1'b1;
            wr_pkt_done_q <= 1'b0;
        end else begin
            wr_pkt_done_q <= wr_beat & bus.s_axis_tlast;
            if (wr_beat) begin
                wr_first_q <= bus.s_axis_tlast;
                wr_addr_q  <= addr_inc(wr_addr);
            end
        end
    end

    // Read FSM
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  rd_remaining_q, rd_remaining_d;
    logic                  rd_issue, rd_valid_q, rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  cmd_fire, credit, beat_pop;
    logic [1:0]            skid_count, occupancy;
    logic                  skid_valid;
    logic [DATA_WIDTH:0]   skid_data;

    assign bus.rd_cmd_ready = (rd_state_q == RD_IDLE) & ~axis_areset;
    assign cmd_fire         = bus.rd_cmd_valid & bus.rd_cmd_ready;
    assign beat_pop         = bus.m_axis_tvalid & bus.m_axis_tready;
    // Buffered plus in-flight beats never exceed the two skid entries; a beat leaving this
    // cycle frees its slot immediately so a ready sink sees one beat per cycle.
    assign occupancy        = skid_count + {1'b0, rd_valid_q};
    assign credit           = (occupancy != 2'd2) || beat_pop;

    always_comb begin
        rd_state_d     = rd_state_q;
        rd_addr_d      = rd_addr_q;
        rd_remaining_d = rd_remaining_q;
        rd_issue       = 1'b0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (cmd_fire) begin
                    rd_addr_d      = bus.rd_cmd_addr;
                    rd_remaining_d = bus.rd_cmd_len;
                    rd_state_d     = RD_BURST;
                end
            end
            RD_BURST: begin
                if (credit) begin
                    rd_issue       = 1'b1;
                    rd_addr_d      = addr_inc(rd_addr_q);
                    rd_remaining_d = rd_remaining_q - LEN_WIDTH'(1);
                    if (rd_remaining_q == '0) begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            rd_state_q <= RD_IDLE;
            rd_valid_q <= 1'b0;
        end else begin
            rd_state_q     <= rd_state_d;
            rd_addr_q      <= rd_addr_d;
            rd_remaining_q <= rd_remaining_d;
            rd_valid_q     <= rd_issue;
        end
    end

    // Memory array: a read and write to the same word in one cycle returns the old word.
    always_ff @(posedge axis_aclk) begin
        if (wr_beat) begin
            for (int i = 0; i < StrbW; i++) begin
                if (bus.s_axis_tstrb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= bus.s_axis_tdata[i*8 +: 8];
                end
            end
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_addr_q];
            rd_last_q <= (rd_remaining_q == '0);
        end
    end

    axis_skid_buffer #(
        .Width (DATA_WIDTH + 1)
    ) u_skid (
        .clk_i       (axis_aclk),
        .rst_i       (axis_areset),
        .in_valid_i  (rd_valid_q),
        .in_data_i   ({rd_last_q, rd_data_q}),
        .out_valid_o (skid_valid),
        .out_data_o  (skid_data),
        .out_ready_i (bus.m_axis_tready),
        .count_o     (skid_count)
    );

    assign bus.m_axis_tvalid = skid_valid & ~axis_areset;
    assign bus.m_axis_tdata  = bus.m_axis_tvalid ? skid_data[DATA_WIDTH-1:0] : '0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid & skid_data[DATA_WIDTH];
    assign bus.m_axis_tstrb  = {StrbW{bus.m_axis_tvalid}};

endmodule

// File: tb/tb_axis_burst_memory.sv
// Directed bench for axis_burst_memory with a reference-memory scoreboard on the read stream.
module tb_axis_burst_memory;

    localparam int unsigned MemSize = 4096;
    localparam int unsigned AW      = 12;
    localparam int unsigned DW      = 32;
    localparam int unsigned LW      = 8;

    logic axis_aclk   = 1'b0;
    logic axis_areset = 1'b1;
    always #5 axis_aclk = ~axis_aclk;

    axis_burst_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    axis_burst_memory #(
        .MEM_SIZE   (MemSize),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .axis_aclk   (axis_aclk),
        .axis_areset (axis_areset),
        .bus         (bus)
    );

    typedef struct packed {logic [31:0] d; logic l;} beat_t;
    typedef struct {logic [31:0] d; logic l; int c;} got_t;

    logic [31:0] ref_mem [MemSize];
    beat_t       exp_q[$];
    got_t        got_q[$];
    logic        m_first = 1'b1;
    logic [11:0] m_next  = '0;
    logic        done_pend = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;
    logic        live = 1'b0;
    logic        pat_en = 1'b0;
    logic [7:0]  pat = 8'b0110_1001;
    int          cyc = 0, cmd_cyc = 0, done_cnt = 0;
    int          n_cmp = 0, n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge axis_aclk) cyc <= cyc + 1;

    // Sink ready: constant 1, or the repeating stall pattern when enabled.
    initial begin
        logic [2:0] idx;
        idx = '0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            if (pat_en) begin
                bus.m_axis_tready = pat[idx];
                idx = idx + 3'd1;
            end else begin
                bus.m_axis_tready = 1'b1;
                idx = '0;
            end
        end
    end

    // Model and compare process
    always @(negedge axis_aclk) begin
        beat_t       b;
        logic [11:0] a;
        if (live) begin
            if (axis_areset) begin
                check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
                check("rst_cmd_ready", 64'(bus.rd_cmd_ready), 64'd0);
                check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
                check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
                check("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
                check("rst_tstrb", 64'(bus.m_axis_tstrb), 64'd0);
                check("rst_done", 64'(bus.wr_pkt_done), 64'd0);
                exp_q.delete();
                m_first    = 1'b1;
                done_pend  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("s_tready", 64'(bus.s_axis_tready), 64'd1);
                check("wr_pkt_done", 64'(bus.wr_pkt_done), 64'(done_pend));
                if (bus.wr_pkt_done) done_cnt++;
                done_pend = 1'b0;
                if (prev_stall) begin
                    check("hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
                    check("hold_data", 64'(bus.m_axis_tdata), 64'(prev_d));
                    check("hold_last", 64'(bus.m_axis_tlast), 64'(prev_l));
                end
                if (bus.m_axis_tvalid) check("tstrb", 64'(bus.m_axis_tstrb), 64'hF);
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected no beat",
                                 bus.m_axis_tdata);
                    end else begin
                        b = exp_q.pop_front();
                        check("rd_data", 64'(bus.m_axis_tdata), 64'(b.d));
                        check("rd_last", 64'(bus.m_axis_tlast), 64'(b.l));
                    end
                    got_q.push_back('{bus.m_axis_tdata, bus.m_axis_tlast, cyc});
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_d     = bus.m_axis_tdata;
                prev_l     = bus.m_axis_tlast;
                if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                    a = m_first ? bus.s_axis_wr_addr : m_next;
                    for (int i = 0; i < 4; i++) begin
                        if (bus.s_axis_tstrb[i]) ref_mem[a][i*8 +: 8] = bus.s_axis_tdata[i*8 +: 8];
                    end
                    m_next    = 12'((int'(a) + 1) % MemSize);
                    m_first   = bus.s_axis_tlast;
                    done_pend = bus.s_axis_tlast;
                end
                if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
                    cmd_cyc = cyc;
                    for (int i = 0; i <= int'(bus.rd_cmd_len); i++) begin
                        a = 12'((int'(bus.rd_cmd_addr) + i) % MemSize);
                        exp_q.push_back('{ref_mem[a], (i == int'(bus.rd_cmd_len))});
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge axis_aclk);
        #1;
    endtask

    task automatic wr_beat(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic l);
        bus.s_axis_wr_addr = a;
        bus.s_axis_tdata   = d;
        bus.s_axis_tstrb   = s;
        bus.s_axis_tlast   = l;
        bus.s_axis_tvalid  = 1'b1;
        @(posedge axis_aclk);
        #1;
        bus.s_axis_tvalid  = 1'b0;
    endtask

    task automatic rd_cmd(input logic [11:0] a, input logic [7:0] l);
        int n;
        n = 0;
        bus.rd_cmd_addr  = a;
        bus.rd_cmd_len   = l;
        bus.rd_cmd_valid = 1'b1;
        @(negedge axis_aclk);
        while (!bus.rd_cmd_ready && n < 200) begin
            @(negedge axis_aclk);
            n++;
        end
        if (!bus.rd_cmd_ready) check("cmd_accept_timeout", 64'(n), 64'd0);
        @(posedge axis_aclk);
        #1;
        bus.rd_cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge axis_aclk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic check_got(input string name, input int i, input logic [31:0] d,
                             input logic l);
        if (i >= got_q.size()) begin
            check({name, "_missing"}, 64'(got_q.size()), 64'(i + 1));
        end else begin
            check({name, "_data"}, 64'(got_q[i].d), 64'(d));
            check({name, "_last"}, 64'(got_q[i].l), 64'(l));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cmd2_cyc;
        bus.s_axis_wr_addr = '0;
        bus.s_axis_tdata   = '0;
        bus.s_axis_tstrb   = '0;
        bus.s_axis_tvalid  = 1'b0;
        bus.s_axis_tlast   = 1'b0;
        bus.rd_cmd_valid   = 1'b0;
        bus.rd_cmd_addr    = '0;
        bus.rd_cmd_len     = '0;
        @(posedge axis_aclk);
        live = 1'b1;
        idle(2);
        axis_areset = 1'b0;
        @(negedge axis_aclk);
        check("cmd_ready_after_reset", 64'(bus.rd_cmd_ready), 64'd1);
        check("tvalid_after_reset", 64'(bus.m_axis_tvalid), 64'd0);
        idle(1);

        // Basic 4-beat packet and burst
        done_cnt = 0;
        for (int i = 0; i < 4; i++) wr_beat(12'h010, 32'h1111_1111 * (i + 1), 4'hF, i == 3);
        idle(2);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
        got_q.delete();
        rd_cmd(12'h010, 8'd3);
        drain(100);
        for (int i = 0; i < 4; i++) check_got("t1", i, 32'h1111_1111 * (i + 1), i == 3);
        if (got_q.size() == 4) begin
            check("t1_latency", 64'(got_q[0].c - cmd_cyc), 64'd2);
            check("t1_back_to_back", 64'(got_q[3].c - got_q[0].c), 64'd3);
        end

        // Byte strobes
        wr_beat(12'h020, 32'hAABB_CCDD, 4'hF, 1'b1);
        wr_beat(12'h020, 32'h1122_3344, 4'h5, 1'b1);
        idle(1);
        got_q.delete();
        rd_cmd(12'h020, 8'd0);
        drain(100);
        check_got("t2", 0, 32'hAA22_CC44, 1'b1);

        // Address wrap on both paths
        wr_beat(12'hFFE, 32'hA0A0_A0A0, 4'hF, 1'b0);
        wr_beat(12'h000, 32'hB0B0_B0B0, 4'hF, 1'b0);
        wr_beat(12'h000, 32'hC0C0_C0C0, 4'hF, 1'b1);
        idle(1);
        got_q.delete();
        rd_cmd(12'hFFE, 8'd2);
        drain(100);
        check_got("t3_a", 0, 32'hA0A0_A0A0, 1'b0);
        check_got("t3_b", 1, 32'hB0B0_B0B0, 1'b0);
        check_got("t3_c", 2, 32'hC0C0_C0C0, 1'b1);
        got_q.delete();
        rd_cmd(12'h000, 8'd0);
        drain(100);
        check_got("t3_zero", 0, 32'hC0C0_C0C0, 1'b1);

        // Back-pressure and overlapping commands
        for (int i = 0; i < 8; i++) wr_beat(12'h200, 32'hB000_0000 + i, 4'hF, i == 7);
        idle(1);
        got_q.delete();
        pat_en = 1'b1;
        rd_cmd(12'h200, 8'd7);
        rd_cmd(12'h010, 8'd3);
        cmd2_cyc = cmd_cyc;
        drain(300);
        pat_en = 1'b0;
        for (int i = 0; i < 8; i++) check_got("t4_b1", i, 32'hB000_0000 + i, i == 7);
        for (int i = 0; i < 4; i++) check_got("t4_b2", 8 + i, 32'h1111_1111 * (i + 1), i == 3);
        if (got_q.size() == 12) check("t4_cmd2_before_drain", 64'(cmd2_cyc < got_q[7].c), 64'd1);
        idle(2);
        got_q.delete();
        rd_cmd(12'h200, 8'd3);
        rd_cmd(12'h010, 8'd3);
        drain(100);
        if (got_q.size() == 8) check("t4_b2_contiguous", 64'(got_q[7].c - got_q[4].c), 64'd3);
        else check("t4_b2_count", 64'(got_q.size()), 64'd8);

        // Reset in the middle of a burst
        got_q.delete();
        rd_cmd(12'h200, 8'd7);
        repeat (3) @(posedge axis_aclk);
        #1;
        axis_areset = 1'b1;
        idle(1);
        @(negedge axis_aclk);
        check("t5_tvalid_in_reset", 64'(bus.m_axis_tvalid), 64'd0);
        check("t5_cmd_ready_in_reset", 64'(bus.rd_cmd_ready), 64'd0);
        idle(1);
        axis_areset = 1'b0;
        idle(6);
        check("t5_beats_before_reset", 64'(got_q.size()), 64'd2);
        @(negedge axis_aclk);
        check("t5_cmd_ready_after", 64'(bus.rd_cmd_ready), 64'd1);
        idle(1);
        got_q.delete();
        rd_cmd(12'h200, 8'd7);
        drain(100);
        check_got("t5_first", 0, 32'hB000_0000, 1'b0);
        check_got("t5_last", 7, 32'hB000_0007, 1'b1);

        // Same-cycle read and write to one word
        wr_beat(12'h100, 32'h0000_0009, 4'hF, 1'b1);
        idle(1);
        got_q.delete();
        rd_cmd(12'h100, 8'd0);
        wr_beat(12'h100, 32'h0000_0005, 4'hF, 1'b1);
        drain(100);
        check_got("t6_old", 0, 32'h0000_0009, 1'b1);
        got_q.delete();
        rd_cmd(12'h100, 8'd0);
        drain(100);
        check_got("t6_new", 0, 32'h0000_0005, 1'b1);

        idle(2);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
